// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer: FSM state
// encodings and the debug command codes.
package pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the executed-cycle and stall-cycle
// statistics. It sticks at all-ones instead of wrapping so the debug unit
// can tell an overflowed count from a small one.
module sat_counter #(
    parameter int N_CNT = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [N_CNT-1:0] o_count
);

    // Clear wins over increment; increment is suppressed once saturated.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline. Decodes debug commands,
// drives the stage enables and PC / IF-ID write controls, inserts load-use
// bubbles into ID/EX and drains the pipeline once HALT leaves ID.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int N_CNT = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    input  logic             i_halt_id,
    input  logic             i_halt_wb,
    input  logic             i_load_use,
    output logic             o_pipe_enable,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_flush_all,
    output logic [2:0]       o_state,
    output logic             o_done,
    output logic             o_cmd_err,
    output logic [N_CNT-1:0] o_cycle_cnt,
    output logic [N_CNT-1:0] o_stall_cnt
);

    state_t state;

    logic cmdRun;
    logic cmdStep;
    logic cmdStop;
    logic cmdAny;
    logic haltGo;
    logic counterClr;

    assign cmdRun  = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmdStep = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmdStop = i_cmd_valid && (i_cmd == CMD_STOP);
    assign cmdAny  = i_cmd_valid && (i_cmd != CMD_NOP);

    // A HALT that is being held in ID by a load-use stall must not start
    // the drain: the instruction ahead of it has not moved on yet.
    assign haltGo = i_halt_id && !i_load_use;

    // Statistics restart whenever a STOP returns the machine to a clean IDLE.
    assign counterClr = cmdStop && ((state == S_IDLE) || (state == S_DONE));

    assign o_state = state;

    // Stage controls decoded from the registered state; load-use only
    // freezes PC and IF/ID while the stages keep moving a bubble into EX.
    always_comb begin
        o_pipe_enable = 1'b0;
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_done        = 1'b0;
        case (state)
            S_RUN, S_STEP: begin
                o_pipe_enable = 1'b1;
                if (i_load_use) begin
                    o_idex_bubble = 1'b1;
                end else begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                end
            end
            S_DRAIN: begin
                o_pipe_enable = 1'b1;
                o_ifid_write  = 1'b1;
                o_ifid_flush  = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register plus the registered flush and command-error pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            o_flush_all <= 1'b0;
            o_cmd_err   <= 1'b0;
        end else begin
            o_flush_all <= 1'b0;
            o_cmd_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmdRun) begin
                        state <= S_RUN;
                    end else if (cmdStep) begin
                        state <= S_STEP;
                    end else if (cmdStop) begin
                        o_flush_all <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (haltGo) begin
                        state <= S_DRAIN;
                        if (cmdAny) begin
                            o_cmd_err <= 1'b1;
                        end
                    end else if (cmdStop) begin
                        state <= S_IDLE;
                    end else if (cmdAny) begin
                        o_cmd_err <= 1'b1;
                    end
                end
                S_STEP: begin
                    state <= haltGo ? S_DRAIN : S_IDLE;
                    if (cmdAny) begin
                        o_cmd_err <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (i_halt_wb) begin
                        state <= S_DONE;
                    end
                    if (cmdAny) begin
                        o_cmd_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (cmdStop) begin
                        state       <= S_IDLE;
                        o_flush_all <= 1'b1;
                    end else if (cmdAny) begin
                        o_cmd_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.N_CNT(N_CNT)) cycleCounter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_pipe_enable),
        .i_clr   (counterClr),
        .o_count (o_cycle_cnt)
    );

    sat_counter #(.N_CNT(N_CNT)) stallCounter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_idex_bubble),
        .i_clr   (counterClr),
        .o_count (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a table of per-cycle vectors whose
// expected outputs go through a scoreboard queue, plus a hand-written
// saturation sequence on a narrow-counter instance.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        pe;
        logic        pw;
        logic        iw;
        logic        ifl;
        logic        bub;
        logic        fa;
        logic        ce;
        logic        dn;
        logic [31:0] cyc;
        logic [31:0] stl;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] cmd;
        logic       hid;
        logic       hwb;
        logic       lu;
        exp_t       exp;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic        i_halt_id;
    logic        i_halt_wb;
    logic        i_load_use;

    logic        pipeEnable, pcWrite, ifidWrite, ifidFlush, idexBubble;
    logic        flushAll, done, cmdErr;
    logic [2:0]  state;
    logic [31:0] cycleCnt, stallCnt;

    logic        pipeEnable4, pcWrite4, ifidWrite4, ifidFlush4, idexBubble4;
    logic        flushAll4, done4, cmdErr4;
    logic [2:0]  state4;
    logic [3:0]  cycleCnt4, stallCnt4;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t expQ[$];

    always #5 i_clk = ~i_clk;

    pipeline_ctrl #(.N_CNT(32)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .i_halt_id     (i_halt_id),
        .i_halt_wb     (i_halt_wb),
        .i_load_use    (i_load_use),
        .o_pipe_enable (pipeEnable),
        .o_pc_write    (pcWrite),
        .o_ifid_write  (ifidWrite),
        .o_ifid_flush  (ifidFlush),
        .o_idex_bubble (idexBubble),
        .o_flush_all   (flushAll),
        .o_state       (state),
        .o_done        (done),
        .o_cmd_err     (cmdErr),
        .o_cycle_cnt   (cycleCnt),
        .o_stall_cnt   (stallCnt)
    );

    pipeline_ctrl #(.N_CNT(4)) dut4 (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .i_halt_id     (i_halt_id),
        .i_halt_wb     (i_halt_wb),
        .i_load_use    (i_load_use),
        .o_pipe_enable (pipeEnable4),
        .o_pc_write    (pcWrite4),
        .o_ifid_write  (ifidWrite4),
        .o_ifid_flush  (ifidFlush4),
        .o_idex_bubble (idexBubble4),
        .o_flush_all   (flushAll4),
        .o_state       (state4),
        .o_done        (done4),
        .o_cmd_err     (cmdErr4),
        .o_cycle_cnt   (cycleCnt4),
        .o_stall_cnt   (stallCnt4)
    );

    // Append one cycle of stimulus with the outputs expected during that cycle.
    task automatic addVec(input logic rst, input logic cv, input logic [1:0] cmd,
                          input logic hid, input logic hwb, input logic lu,
                          input logic [2:0] st, input logic pe, input logic pw,
                          input logic iw, input logic ifl, input logic bub,
                          input logic fa, input logic ce, input logic dn,
                          input int cyc, input int stl);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cmd = cmd; v.hid = hid; v.hwb = hwb; v.lu = lu;
        v.exp = '{st: st, pe: pe, pw: pw, iw: iw, ifl: ifl, bub: bub,
                  fa: fa, ce: ce, dn: dn, cyc: cyc, stl: stl};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        i_reset     = v.rst;
        i_cmd_valid = v.cv;
        i_cmd       = v.cmd;
        i_halt_id   = v.hid;
        i_halt_wb   = v.hwb;
        i_load_use  = v.lu;
        expQ.push_back(v.exp);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        exp_t a;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL vec%0d scoreboard empty", idx);
            return;
        end
        e = expQ.pop_front();
        a = '{st: state, pe: pipeEnable, pw: pcWrite, iw: ifidWrite, ifl: ifidFlush,
              bub: idexBubble, fa: flushAll, ce: cmdErr, dn: done,
              cyc: cycleCnt, stl: stallCnt};
        if (e.st == S_DRAIN) begin
            a.iw = 1'b0;
            e.iw = 1'b0;
        end
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL vec%0d got st=%0d pe%b pw%b iw%b ifl%b bub%b fa%b ce%b dn%b cyc=%0d stl=%0d expected st=%0d pe%b pw%b iw%b ifl%b bub%b fa%b ce%b dn%b cyc=%0d stl=%0d",
                     idx, a.st, a.pe, a.pw, a.iw, a.ifl, a.bub, a.fa, a.ce, a.dn, a.cyc, a.stl,
                     e.st, e.pe, e.pw, e.iw, e.ifl, e.bub, e.fa, e.ce, e.dn, e.cyc, e.stl);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        addVec(1,0,CMD_NOP,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 0,0);
        // RUN for 10 cycles, STOP on the tenth
        addVec(0,1,CMD_RUN,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 0,0);
        for (int i = 0; i < 10; i++)
            addVec(0,(i == 9),CMD_STOP,0,0,0, S_RUN,1,1,1,0,0,0,0,0, i,0);
        addVec(0,1,CMD_RUN,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 10,0);
        // Single load-use stall in RUN
        addVec(0,0,CMD_NOP,0,0,0, S_RUN,1,1,1,0,0,0,0,0, 10,0);
        addVec(0,0,CMD_NOP,0,0,1, S_RUN,1,0,0,0,1,0,0,0, 11,0);
        addVec(0,0,CMD_NOP,0,0,0, S_RUN,1,1,1,0,0,0,0,0, 12,1);
        // STEP while running is illegal
        addVec(0,1,CMD_STEP,0,0,0, S_RUN,1,1,1,0,0,0,0,0, 13,1);
        addVec(0,0,CMD_NOP,0,0,0, S_RUN,1,1,1,0,0,0,1,0, 14,1);
        // HALT in ID, HALT reaches WB three cycles later
        addVec(0,0,CMD_NOP,1,0,0, S_RUN,1,1,1,0,0,0,0,0, 15,1);
        addVec(0,0,CMD_NOP,0,0,0, S_DRAIN,1,0,1,1,0,0,0,0, 16,1);
        addVec(0,0,CMD_NOP,0,0,1, S_DRAIN,1,0,1,1,0,0,0,0, 17,1);
        addVec(0,0,CMD_NOP,0,1,0, S_DRAIN,1,0,1,1,0,0,0,0, 18,1);
        addVec(0,0,CMD_NOP,0,0,0, S_DONE,0,0,0,0,0,0,0,1, 19,1);
        addVec(0,1,CMD_RUN,0,0,0, S_DONE,0,0,0,0,0,0,0,1, 19,1);
        addVec(0,1,CMD_STOP,0,0,0, S_DONE,0,0,0,0,0,0,1,1, 19,1);
        addVec(0,0,CMD_NOP,0,0,0, S_IDLE,0,0,0,0,0,1,0,0, 0,0);
        // HALT held in ID by a two-cycle stall
        addVec(0,1,CMD_RUN,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 0,0);
        addVec(0,0,CMD_NOP,1,0,1, S_RUN,1,0,0,0,1,0,0,0, 0,0);
        addVec(0,0,CMD_NOP,1,0,1, S_RUN,1,0,0,0,1,0,0,0, 1,1);
        addVec(0,0,CMD_NOP,1,0,0, S_RUN,1,1,1,0,0,0,0,0, 2,2);
        addVec(0,1,CMD_STOP,0,1,0, S_DRAIN,1,0,1,1,0,0,0,0, 3,2);
        addVec(0,0,CMD_NOP,0,0,0, S_DONE,0,0,0,0,0,0,1,1, 4,2);
        addVec(0,1,CMD_STOP,0,0,0, S_DONE,0,0,0,0,0,0,0,1, 4,2);
        addVec(0,1,CMD_RUN,0,0,0, S_IDLE,0,0,0,0,0,1,0,0, 0,0);
        // HALT beats a simultaneous STOP, then reset in DRAIN
        addVec(0,1,CMD_STOP,1,0,0, S_RUN,1,1,1,0,0,0,0,0, 0,0);
        addVec(0,0,CMD_NOP,0,0,0, S_DRAIN,1,0,1,1,0,0,1,0, 1,0);
        addVec(1,0,CMD_NOP,0,0,0, S_DRAIN,1,0,1,1,0,0,0,0, 2,0);
        addVec(0,0,CMD_NOP,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 0,0);
        // Three single steps
        for (int i = 0; i < 3; i++) begin
            addVec(0,1,CMD_STEP,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, i,0);
            addVec(0,0,CMD_NOP,0,0,0, S_STEP,1,1,1,0,0,0,0,0, i,0);
        end
        // STEP onto a HALT drains; STOP in IDLE pulses flush
        addVec(0,1,CMD_STEP,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 3,0);
        addVec(0,0,CMD_NOP,1,0,0, S_STEP,1,1,1,0,0,0,0,0, 3,0);
        addVec(0,0,CMD_NOP,0,1,0, S_DRAIN,1,0,1,1,0,0,0,0, 4,0);
        addVec(0,1,CMD_STOP,0,0,0, S_DONE,0,0,0,0,0,0,0,1, 5,0);
        addVec(0,1,CMD_STOP,0,0,0, S_IDLE,0,0,0,0,0,1,0,0, 0,0);
        addVec(0,1,CMD_NOP,0,0,0, S_IDLE,0,0,0,0,0,1,0,0, 0,0);
        addVec(0,0,CMD_NOP,0,0,0, S_IDLE,0,0,0,0,0,0,0,0, 0,0);

        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = CMD_NOP;
        i_halt_id = 1'b0; i_halt_wb = 1'b0; i_load_use = 1'b0;
        repeat (2) @(posedge i_clk);

        foreach (vecs[i]) begin
            @(negedge i_clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i);
        end

        // Saturation of a 4-bit counter over 20 running cycles
        @(negedge i_clk);
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_halt_id = 1'b0;
        i_halt_wb = 1'b0; i_load_use = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0; i_cmd_valid = 1'b1; i_cmd = CMD_RUN;
        @(negedge i_clk);
        i_cmd_valid = 1'b0; i_cmd = CMD_NOP;
        #1;
        checkValue("sat_start", {28'd0, cycleCnt4}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            #1;
            checkValue("sat_n4", {28'd0, cycleCnt4}, (i > 15) ? 32'd15 : 32'(i));
        end
        checkValue("sat_n32", cycleCnt, 32'd20);
        checkValue("sat_state", {29'd0, state4}, {29'd0, S_RUN});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
